// File: rtl/ll_req_issuer.sv
// rtl/ll_req_issuer.sv - command FIFO and request sequencer for the linked-list engine
//
// Buffers host commands in a FIFO_DEPTH-entry FIFO and issues them one at a time
// to the linked-list engine, waiting for the response before issuing the next.
// Optional response watchdog: define LL_REQ_ISSUER_TIMEOUT_EN.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   host_cmd_vld / host_cmd_rdy       host command handshake
//   host_main_op, host_spec, host_ll_num, host_pos, host_data   command fields
//   req_vld, req_main_op, req_spec, req_ll_num_in, req_pos, req_data   engine request
//   intf_ready                        engine accepts the request
//   resp_gen_cmpltd                   engine response-complete pulse
//   busy                              FIFO non-empty or a command in flight
//   cmd_done                          one-cycle pulse per completed command
//   timeout_err                       sticky watchdog error (0 when watchdog absent)
//   issued_cnt, done_cnt              wrapping 8-bit request/response counters
module ll_req_issuer #(
    parameter int FIFO_DEPTH         = 4,
    parameter int TIMEOUT_CYCLES     = 200,
    parameter int MAINOP_WIDTH       = 3,
    parameter int SPEC_WIDTH         = 2,
    parameter int HEADPTR_ADDR_WIDTH = 4,
    parameter int NODENUM_WIDTH      = 8,
    parameter int DATA_WIDTH         = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          host_cmd_vld,
    output logic                          host_cmd_rdy,
    input  logic [MAINOP_WIDTH-1:0]       host_main_op,
    input  logic [SPEC_WIDTH-1:0]         host_spec,
    input  logic [HEADPTR_ADDR_WIDTH-1:0] host_ll_num,
    input  logic [NODENUM_WIDTH-1:0]      host_pos,
    input  logic [DATA_WIDTH-1:0]         host_data,
    output logic                          req_vld,
    output logic [MAINOP_WIDTH-1:0]       req_main_op,
    output logic [SPEC_WIDTH-1:0]         req_spec,
    output logic [HEADPTR_ADDR_WIDTH-1:0] req_ll_num_in,
    output logic [NODENUM_WIDTH-1:0]      req_pos,
    output logic [DATA_WIDTH-1:0]         req_data,
    input  logic                          intf_ready,
    input  logic                          resp_gen_cmpltd,
    output logic                          busy,
    output logic                          cmd_done,
    output logic                          timeout_err,
    output logic [7:0]                    issued_cnt,
    output logic [7:0]                    done_cnt
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CMD_W = MAINOP_WIDTH + SPEC_WIDTH + HEADPTR_ADDR_WIDTH
                         + NODENUM_WIDTH + DATA_WIDTH;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // ---------------- command FIFO ----------------
    logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [CMD_W-1:0] cmd_in;
    logic [CMD_W-1:0] head;

    // ---------------- sequencer ----------------
    logic [1:0]       state_q, state_d;
    logic             req_vld_q, req_vld_d;
    logic [CMD_W-1:0] req_cmd_q, req_cmd_d;
    logic             cmd_done_q, cmd_done_d;
    logic [7:0]       issued_cnt_q, issued_cnt_d;
    logic [7:0]       done_cnt_q, done_cnt_d;

`ifdef LL_REQ_ISSUER_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wdog_q, wdog_d;
    logic       timeout_err_q, timeout_err_d;
`endif

    assign fifo_full    = (count_q == FULL_CNT);
    assign fifo_empty   = (count_q == '0);
    assign host_cmd_rdy = ~fifo_full;
    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign push   = host_cmd_vld & ~fifo_full;
    // Pop only from the registered count, so a fresh entry is visible next cycle.
    assign pop    = (state_q == ST_IDLE) & ~fifo_empty;
    assign cmd_in = {host_main_op, host_spec, host_ll_num, host_pos, host_data};
    assign head   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_vld_d    = req_vld_q;
        req_cmd_d    = req_cmd_q;
        cmd_done_d   = 1'b0;
        issued_cnt_d = issued_cnt_q;
        done_cnt_d   = done_cnt_q;
`ifdef LL_REQ_ISSUER_TIMEOUT_EN
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    req_cmd_d = head;
                    req_vld_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (intf_ready) begin
                    issued_cnt_d = issued_cnt_q + 8'd1;
                    req_vld_d    = 1'b0;
                    state_d      = ST_WAIT;
`ifdef LL_REQ_ISSUER_TIMEOUT_EN
                    wdog_d       = 8'd0;
`endif
                end
            end
            ST_WAIT: begin
                // A response in the expiry cycle still completes the command.
                if (resp_gen_cmpltd) begin
                    done_cnt_d = done_cnt_q + 8'd1;
                    cmd_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end
`ifdef LL_REQ_ISSUER_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                req_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            req_vld_q    <= 1'b0;
            req_cmd_q    <= '0;
            cmd_done_q   <= 1'b0;
            issued_cnt_q <= 8'd0;
            done_cnt_q   <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            req_vld_q    <= req_vld_d;
            req_cmd_q    <= req_cmd_d;
            cmd_done_q   <= cmd_done_d;
            issued_cnt_q <= issued_cnt_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

`ifdef LL_REQ_ISSUER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q        <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req_vld    = req_vld_q;
    assign {req_main_op, req_spec, req_ll_num_in, req_pos, req_data} = req_cmd_q;
    assign cmd_done   = cmd_done_q;
    assign issued_cnt = issued_cnt_q;
    assign done_cnt   = done_cnt_q;
    assign busy       = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_ll_req_issuer.sv
// tb/tb_ll_req_issuer.sv - self-checking bench for ll_req_issuer
module tb_ll_req_issuer;

    localparam int DEPTH = 4;
    localparam int TO    = 200;
    localparam int MW = 3, SW = 2, LW = 4, NW = 8, DW = 8;
`ifdef LL_REQ_ISSUER_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif
    localparam logic [MW-1:0] OP_ADD    = 3'd1;
    localparam logic [SW-1:0] SPEC_TAIL = 2'd1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          host_cmd_vld, host_cmd_rdy;
    logic [MW-1:0] host_main_op;
    logic [SW-1:0] host_spec;
    logic [LW-1:0] host_ll_num;
    logic [NW-1:0] host_pos;
    logic [DW-1:0] host_data;
    logic          req_vld;
    logic [MW-1:0] req_main_op;
    logic [SW-1:0] req_spec;
    logic [LW-1:0] req_ll_num_in;
    logic [NW-1:0] req_pos;
    logic [DW-1:0] req_data;
    logic          intf_ready, resp_gen_cmpltd;
    logic          busy, cmd_done, timeout_err;
    logic [7:0]    issued_cnt, done_cnt;

    always #5 clk = ~clk;

    ll_req_issuer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .host_cmd_vld(host_cmd_vld), .host_cmd_rdy(host_cmd_rdy),
        .host_main_op(host_main_op), .host_spec(host_spec),
        .host_ll_num(host_ll_num), .host_pos(host_pos), .host_data(host_data),
        .req_vld(req_vld), .req_main_op(req_main_op), .req_spec(req_spec),
        .req_ll_num_in(req_ll_num_in), .req_pos(req_pos), .req_data(req_data),
        .intf_ready(intf_ready), .resp_gen_cmpltd(resp_gen_cmpltd),
        .busy(busy), .cmd_done(cmd_done), .timeout_err(timeout_err),
        .issued_cnt(issued_cnt), .done_cnt(done_cnt)
    );

    typedef struct {
        logic [MW-1:0] op;
        logic [SW-1:0] spec;
        logic [LW-1:0] ll;
        logic [NW-1:0] pos;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        bit            vld;
        logic [DW-1:0] data;
        bit            rdy_in;
        bit            resp;
        bit            e_rdy;
        bit            e_vld;
        logic [DW-1:0] e_data;
        bit            e_done;
        bit            e_busy;
        int            e_iss;
        int            e_dn;
    } vec_t;

    int total  = 0;
    int passed = 0;

    // Reference model: queue of buffered commands plus the phase of the single
    // in-flight command (0 none, 1 offered to engine, 2 awaiting response).
    cmd_t m_fifo[$];
    cmd_t m_cur;
    int   m_phase, m_iss, m_dn, m_wait;
    bit   m_done, m_terr;

    vec_t tbl[9];
    cmd_t got_q[$];
    int   iss_before;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic cmd_t mk(input logic [DW-1:0] d);
        cmd_t c;
        c.op = OP_ADD; c.spec = SPEC_TAIL; c.ll = 4'd1; c.pos = 8'd0; c.data = d;
        return c;
    endfunction

    task automatic drive(input bit vld, input cmd_t c);
        host_cmd_vld = vld;
        host_main_op = c.op; host_spec = c.spec; host_ll_num = c.ll;
        host_pos = c.pos; host_data = c.data;
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_cur = '{default: 0};
        m_phase = 0; m_iss = 0; m_dn = 0; m_wait = 0; m_done = 0; m_terr = 0;
    endtask

    task automatic check_model();
        chk("host_cmd_rdy", 32'(host_cmd_rdy), 32'(m_fifo.size() < DEPTH));
        chk("busy", 32'(busy), 32'(m_fifo.size() > 0 || m_phase != 0));
        chk("req_vld", 32'(req_vld), 32'(m_phase == 1));
        chk("cmd_done", 32'(cmd_done), 32'(m_done));
        chk("issued_cnt", 32'(issued_cnt), 32'(m_iss % 256));
        chk("done_cnt", 32'(done_cnt), 32'(m_dn % 256));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (m_phase == 1) begin
            chk("req_fields", {req_main_op, req_spec, req_ll_num_in, req_pos, req_data},
                32'({m_cur.op, m_cur.spec, m_cur.ll, m_cur.pos, m_cur.data}));
        end
    endtask

    task automatic model_step();
        bit   push, pop;
        cmd_t in;
        in.op = host_main_op; in.spec = host_spec; in.ll = host_ll_num;
        in.pos = host_pos; in.data = host_data;
        push = host_cmd_vld && (m_fifo.size() < DEPTH);
        pop  = (m_phase == 0) && (m_fifo.size() > 0);
        m_done = 0;
        case (m_phase)
            0: if (pop) begin m_cur = m_fifo.pop_front(); m_phase = 1; end
            1: if (intf_ready) begin m_iss++; m_phase = 2; m_wait = 0; end
            default: begin
                if (resp_gen_cmpltd) begin
                    m_dn++; m_done = 1; m_phase = 0;
                end else begin
                    m_wait++;
                    if (TIMEOUT_ON && m_wait == TO) begin m_terr = 1; m_phase = 0; end
                end
            end
        endcase
        if (push) m_fifo.push_back(in);
    endtask

    // Inputs for this cycle are already driven; sampled at the falling edge.
    task automatic cycle();
        check_model();
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, mk(8'h00));
        intf_ready = 1'b0;
        resp_gen_cmpltd = 1'b0;
        model_reset();

        //            vld data  rdy rsp | e_rdy e_vld e_data e_done e_busy iss dn
        tbl[0] = '{1, 8'hA5, 1, 0,  1, 0, 8'h00, 0, 0, 0, 0};
        tbl[1] = '{0, 8'h00, 1, 0,  1, 0, 8'h00, 0, 1, 0, 0};
        tbl[2] = '{0, 8'h00, 1, 0,  1, 1, 8'hA5, 0, 1, 0, 0};
        tbl[3] = '{0, 8'h00, 1, 0,  1, 0, 8'h00, 0, 1, 1, 0};
        tbl[4] = '{0, 8'h00, 1, 0,  1, 0, 8'h00, 0, 1, 1, 0};
        tbl[5] = '{0, 8'h00, 1, 1,  1, 0, 8'h00, 0, 1, 1, 0};
        tbl[6] = '{0, 8'h00, 1, 0,  1, 0, 8'h00, 1, 0, 1, 1};
        tbl[7] = '{0, 8'h00, 1, 1,  1, 0, 8'h00, 0, 0, 1, 1};
        tbl[8] = '{0, 8'h00, 1, 0,  1, 0, 8'h00, 0, 0, 1, 1};

        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single command, then a spurious response while idle.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].vld, mk(tbl[i].data));
            intf_ready      = tbl[i].rdy_in;
            resp_gen_cmpltd = tbl[i].resp;
            chk($sformatf("vec%0d.host_cmd_rdy", i), 32'(host_cmd_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d.req_vld", i), 32'(req_vld), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) chk($sformatf("vec%0d.req_data", i), 32'(req_data), 32'(tbl[i].e_data));
            chk($sformatf("vec%0d.cmd_done", i), 32'(cmd_done), 32'(tbl[i].e_done));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d.issued_cnt", i), 32'(issued_cnt), 32'(tbl[i].e_iss));
            chk($sformatf("vec%0d.done_cnt", i), 32'(done_cnt), 32'(tbl[i].e_dn));
            cycle();
        end

        // Backpressure: engine holds intf_ready low for 10 cycles while offered.
        intf_ready = 1'b0; resp_gen_cmpltd = 1'b0;
        drive(1'b1, mk(8'h3C)); cycle();
        drive(1'b0, mk(8'h00)); run(1);
        run(10);
        chk("bp.issued_hold", 32'(issued_cnt), 32'd1);
        intf_ready = 1'b1; run(1);
        chk("bp.accepted", 32'(issued_cnt), 32'd2);
        intf_ready = 1'b0; run(2);
        resp_gen_cmpltd = 1'b1; run(1);
        resp_gen_cmpltd = 1'b0; run(2);

        // Full FIFO: five pushes with the engine stalled, then a refused sixth.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mk(8'h10 + 8'(i))); cycle();
        end
        chk("full.rdy_low", 32'(host_cmd_rdy), 32'd0);
        drive(1'b1, mk(8'h99)); run(2);
        drive(1'b0, mk(8'h00));
        got_q.delete();
        intf_ready = 1'b1; resp_gen_cmpltd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (req_vld && intf_ready) got_q.push_back(mk(req_data));
            cycle();
        end
        resp_gen_cmpltd = 1'b0;
        chk("full.count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            chk($sformatf("full.order%0d", i), 32'(got_q[i].data), 32'(8'h10 + 8'(i)));

        // Watchdog behaviour.
        iss_before = m_iss;
`ifdef LL_REQ_ISSUER_TIMEOUT_EN
        drive(1'b1, mk(8'h51)); cycle();
        drive(1'b1, mk(8'h52)); cycle();
        drive(1'b0, mk(8'h00));
        run(TO + 10);
        chk("to.timeout_err", 32'(timeout_err), 32'd1);
        chk("to.next_issued", 32'(issued_cnt), 32'((iss_before + 2) % 256));
        // Second command: response arrives exactly in the expiry cycle.
        for (int b = 0; b < 20 && m_phase != 2; b++) cycle();
        chk("to.in_wait", 32'(m_phase), 32'd2);
        while (m_phase == 2 && m_wait < TO - 1) cycle();
        resp_gen_cmpltd = 1'b1; cycle();
        resp_gen_cmpltd = 1'b0;
        chk("to.resp_wins", 32'(cmd_done), 32'd1);
        run(3);
`else
        drive(1'b1, mk(8'h51)); cycle();
        drive(1'b0, mk(8'h00));
        run(1002);
        chk("noto.still_busy", 32'(busy), 32'd1);
        chk("noto.no_err", 32'(timeout_err), 32'd0);
        resp_gen_cmpltd = 1'b1; cycle();
        resp_gen_cmpltd = 1'b0; cycle();
        chk("noto.done_after_wait", 32'(done_cnt), 32'(m_dn % 256));
        run(2);
`endif

        // Reset in WAIT_RESP with two commands queued.
        intf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(8'h61 + 8'(i))); cycle();
        end
        drive(1'b0, mk(8'h00));
        chk("rst.pre_wait", 32'(m_phase), 32'd2);
        chk("rst.pre_queued", 32'(m_fifo.size()), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst.req_vld", 32'(req_vld), 32'd0);
        chk("rst.fields", {req_main_op, req_spec, req_ll_num_in, req_pos, req_data}, 32'd0);
        chk("rst.cmd_done", 32'(cmd_done), 32'd0);
        chk("rst.timeout_err", 32'(timeout_err), 32'd0);
        chk("rst.counts", {issued_cnt, done_cnt}, 32'd0);
        chk("rst.rdy", 32'(host_cmd_rdy), 32'd1);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        run(3);
        chk("rst.busy_after", 32'(busy), 32'd0);

        // Randomized traffic, includes spurious responses and counter wrap.
        for (int i = 0; i < 3000; i++) begin
            cmd_t c;
            c.op = 3'($urandom); c.spec = 2'($urandom); c.ll = 4'($urandom);
            c.pos = 8'($urandom); c.data = 8'($urandom);
            drive(1'($urandom_range(0, 1)), c);
            intf_ready      = ($urandom_range(0, 9) < 6);
            resp_gen_cmpltd = ($urandom_range(0, 9) < 3);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
